seven_segment_scanner: RTL



---
 rtl/seven_segment_scanner.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_scanner
// Description : Time-multiplexed hex driver for a multi-digit common-anode
//               7-segment display with leading-zero blanking and guard time.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
    parameter int DIGITS        = 4,
    parameter int REFRESH_DIV   = 1000,
    parameter int GUARD         = 16,
    parameter int ACTIVE_LOW_AN = 1,
    localparam int IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_leading,
    input  logic                  enable,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic [DIGITS-1:0]     anodes,
    output logic [IDX_W-1:0]      digit_idx
);

    localparam int                CNT_W      = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  c_guard    = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0]  c_idx_last = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] c_an_off   = (ACTIVE_LOW_AN != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        c_seg_off  = 7'b1111111;

    logic [4*DIGITS-1:0] shadow_q,    shadow_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic [6:0]          seg_q,       seg_d;
    logic                dp_q,        dp_d;
    logic [DIGITS-1:0]   an_q,        an_d;

    logic [3:0]          w_nibble;
    logic                w_upper_zero;
    logic                w_blank;
    logic                w_in_guard;
    logic [DIGITS-1:0]   w_onehot;

    // Segment order is g..a, active low.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        if (load) begin
            shadow_d    = value;
            shadow_dp_d = dp_in;
        end
        if (enable) begin
            if (cnt_q == c_cnt_last) begin
                cnt_d = '0;
                idx_d = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        w_nibble     = shadow_q[4*idx_q +: 4];
        w_upper_zero = 1'b1;
        // A digit is a leading zero only if it and every more-significant nibble are zero.
        for (int j = 0; j < DIGITS; j++) begin
            if ((j >= int'(idx_q)) && (shadow_q[4*j +: 4] != 4'h0)) begin
                w_upper_zero = 1'b0;
            end
        end
        w_blank    = blank_leading && (idx_q != '0) && w_upper_zero;
        w_in_guard = (cnt_q < c_guard);
        w_onehot   = DIGITS'(1) << idx_q;

        seg_d = c_seg_off;
        dp_d  = 1'b1;
        an_d  = c_an_off;
        if (enable && !w_in_guard) begin
            an_d  = (ACTIVE_LOW_AN != 0) ? ~w_onehot : w_onehot;
            seg_d = w_blank ? c_seg_off : hex_to_seg(w_nibble);
            dp_d  = ~shadow_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            seg_q       <= c_seg_off;
            dp_q        <= 1'b1;
            an_q        <= c_an_off;
        end else begin
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign segments  = seg_q;
    assign dp        = dp_q;
    assign anodes    = an_q;
    assign digit_idx = idx_q;

endmodule
`default_nettype wire
